// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared encodings for the multicycle MIPS control unit: FSM state enum,
// opcode and funct constants, the ALU-op type with its values, the ALU
// control codes, and the bundle of Moore-decoded control signals.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Controller states, held in a 4-bit register.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // Primary opcodes (instruction[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instruction[5:0]).
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU operation class requested by the FSM.
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_FUNCT = 2'b10;
    localparam aluop_t ALUOP_ADD2  = 2'b11;

    // ALU control codes driven to the datapath.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Moore outputs decoded from the state register.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/aludec.sv
// -----------------------------------------------------------------------------
// aludec
// ALU control decoder. Maps the FSM's ALU-op class (and, for R-type, the
// funct field) to the 3-bit ALU operation.
// Ports:
//   aluop      in  2  operation class from the FSM
//   funct      in  6  instruction[5:0]
//   alucontrol out 3  ALU operation code
// -----------------------------------------------------------------------------
module aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Operation select; unrecognised funct codes fall back to add.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:  alucontrol = ALU_ADD;
            ALUOP_SUB:  alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            ALUOP_ADD2: alucontrol = ALU_ADD;
            default:    alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// A 12-state Moore FSM sequences each instruction; ALU control is decoded by
// the aludec sub-module.
// Ports:
//   clk        in   1  clock, all state updates on rising edge
//   reset      in   1  asynchronous active-high reset (forces FETCH)
//   op         in   6  instruction[31:26]
//   funct      in   6  instruction[5:0]
//   zero       in   1  ALU zero flag
//   pcen       out  1  PC register enable
//   iord       out  1  memory address select (0 = PC, 1 = ALU result)
//   irwrite    out  1  instruction register write enable
//   memwrite   out  1  data memory write enable
//   regwrite   out  1  register file write enable
//   regdst     out  1  register destination select
//   memtoreg   out  1  write-back data select
//   alusrca    out  1  ALU A operand select
//   alusrcb    out  2  ALU B operand select
//   pcsrc      out  2  next-PC select
//   alucontrol out  3  ALU operation
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_s;

    // State register; reset takes effect immediately, even mid-instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode. op is only looked at in DECODE and
    // MEMADR, so it may change freely during the other states.
    always_comb begin
        state_d = S_FETCH;
        ctrl_s  = CTRL_NONE;
        case (state_q)
            S_FETCH: begin
                state_d        = S_DECODE;
                ctrl_s.alusrcb = 2'b01;
                ctrl_s.irwrite = 1'b1;
                ctrl_s.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl_s.alusrcb = 2'b11;
                case (op)
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEXEC;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                state_d     = S_MEMWB;
                ctrl_s.iord = 1'b1;
            end
            S_MEMWB: begin
                state_d         = S_FETCH;
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
            end
            S_MEMWR: begin
                state_d         = S_FETCH;
                ctrl_s.iord     = 1'b1;
                ctrl_s.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                state_d        = S_ALUWB;
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                state_d         = S_FETCH;
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
            end
            S_BRANCH: begin
                state_d        = S_FETCH;
                ctrl_s.alusrca = 1'b1;
                ctrl_s.aluop   = ALUOP_SUB;
                ctrl_s.pcsrc   = 2'b01;
                ctrl_s.branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                state_d        = S_ADDIWB;
                ctrl_s.alusrca = 1'b1;
                ctrl_s.alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                state_d         = S_FETCH;
                ctrl_s.regwrite = 1'b1;
            end
            S_JUMP: begin
                state_d        = S_FETCH;
                ctrl_s.pcsrc   = 2'b10;
                ctrl_s.pcwrite = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
                ctrl_s  = CTRL_NONE;
            end
        endcase
    end

    aludec u_aludec (
        .aluop      (ctrl_s.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Write enables are masked while reset is held: the state already shows
    // FETCH, but no PC/IR/memory/register update may be requested until the
    // first edge after release.
    assign pcen     = (ctrl_s.pcwrite | (ctrl_s.branch & zero)) & ~reset;
    assign irwrite  = ctrl_s.irwrite  & ~reset;
    assign memwrite = ctrl_s.memwrite & ~reset;
    assign regwrite = ctrl_s.regwrite & ~reset;

    assign iord     = ctrl_s.iord;
    assign regdst   = ctrl_s.regdst;
    assign memtoreg = ctrl_s.memtoreg;
    assign alusrca  = ctrl_s.alusrca;
    assign alusrcb  = ctrl_s.alusrcb;
    assign pcsrc    = ctrl_s.pcsrc;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Scoreboard bench: the driver walks each instruction through its list of
// control steps, pushing the expected output vector for every cycle; a
// negedge monitor pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {pcen,iord,irwrite,memwrite,regwrite,regdst,
    // memtoreg,alusrca,alusrcb,pcsrc,alucontrol}.
    logic [14:0] obs;
    assign obs = {pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
                  alusrca, alusrcb, pcsrc, alucontrol};

    // Named control steps of the instruction flow.
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                   ST_MEMWB = 4, ST_MEMWR = 5, ST_EXECUTE = 6, ST_ALUWB = 7,
                   ST_BRANCH = 8, ST_ADDIEXEC = 9, ST_ADDIWB = 10, ST_JUMP = 11;

    typedef struct {
        logic [14:0] vec;
        int          step;
        int          instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   instr_no = 0;
    logic [14:0] rst_vec;

    function automatic logic [14:0] mk(input logic pc, input logic io, input logic ir,
                                       input logic mw, input logic rw, input logic rd,
                                       input logic mr, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic [2:0] ac);
        return {pc, io, ir, mw, rw, rd, mr, sa, sb, ps, ac};
    endfunction

    // R-type ALU operation table.
    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs during one control step.
    function automatic logic [14:0] step_vec(input int st, input logic [5:0] fn, input logic z);
        case (st)
            ST_FETCH:    return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010);
            ST_DECODE:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010);
            ST_MEMADR:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010);
            ST_MEMRD:    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010);
            ST_MEMWB:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010);
            ST_MEMWR:    return mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010);
            ST_EXECUTE:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, rtype_alu(fn));
            ST_ALUWB:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010);
            ST_BRANCH:   return mk(z,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'b110);
            ST_ADDIEXEC: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010);
            ST_ADDIWB:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010);
            ST_JUMP:     return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'b010);
            default:     return 15'h0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drive one instruction, starting in the FETCH cycle (just after the edge).
    // zmode: 0/1 = fixed zero flag, 2 = random every cycle.
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int zmode);
        int   seq[$];
        exp_t e;
        logic z;
        seq.push_back(ST_FETCH);
        seq.push_back(ST_DECODE);
        case (iop)
            6'b100011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMRD); seq.push_back(ST_MEMWB); end
            6'b101011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWR); end
            6'b000000: begin seq.push_back(ST_EXECUTE); seq.push_back(ST_ALUWB); end
            6'b001000: begin seq.push_back(ST_ADDIEXEC); seq.push_back(ST_ADDIWB); end
            6'b000100: seq.push_back(ST_BRANCH);
            6'b000010: seq.push_back(ST_JUMP);
            default:   ;
        endcase
        for (int k = 0; k < seq.size(); k++) begin
            // Only DECODE/MEMADR see the real opcode and only EXECUTE the real
            // funct; every other cycle gets noise, which must not matter.
            op    = (seq[k] == ST_DECODE || seq[k] == ST_MEMADR) ? iop : 6'($urandom);
            funct = (seq[k] == ST_EXECUTE) ? ifn : 6'($urandom);
            z     = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            zero  = z;
            e.vec   = step_vec(seq[k], ifn, z);
            e.step  = seq[k];
            e.instr = instr_no;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        instr_no++;
    endtask

    task automatic run_random(input int count);
        logic [5:0] known_ops[6]   = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] unknown_ops[5] = '{6'b111111, 6'b000011, 6'b001101, 6'b100000, 6'b101000};
        logic [5:0] functs[7]      = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
        logic [5:0] iop;
        logic [5:0] ifn;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 6) == 0) iop = unknown_ops[$urandom_range(0, 4)];
            else                           iop = known_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) ifn = 6'($urandom);
            else                           ifn = functs[$urandom_range(0, 6)];
            run_instr(iop, ifn, 2);
        end
    endtask

    // Scoreboard monitor: compare every cycle for which an expectation exists.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (obs !== mon_e.vec) begin
                n_fail++;
                $display("FAIL step_outputs instr=%0d step=%0d got=%h expected=%h",
                         mon_e.instr, mon_e.step, obs, mon_e.vec);
            end
        end
    end

    initial begin
        rst_vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010);
        reset = 1'b0;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;

        // Reset: FETCH values with all write enables and pcen held low.
        #2 reset = 1'b1;
        #1 chk("reset_async", obs, rst_vec);
        @(posedge clk);
        #1 chk("reset_held_edge", obs, rst_vec);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("release_fetch", obs, step_vec(ST_FETCH, 6'b000000, 1'b0));

        // Directed instruction flows.
        run_instr(6'b100011, 6'b000000, 2);   // lw
        run_instr(6'b000000, 6'b101010, 2);   // R-type slt
        run_instr(6'b000100, 6'b000000, 1);   // beq taken
        run_instr(6'b000100, 6'b000000, 0);   // beq not taken
        run_instr(6'b101011, 6'b000000, 2);   // sw
        run_instr(6'b111111, 6'b000000, 2);   // unknown op
        run_instr(6'b001000, 6'b000000, 2);   // addi
        run_instr(6'b000010, 6'b000000, 2);   // j

        run_random(80);

        // Reset asserted in the middle of a store.
        op    = 6'b101011;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 chk("memwr_before_reset", obs, step_vec(ST_MEMWR, 6'b000000, 1'b0));
        #2 reset = 1'b1;
        #1 chk("memwr_async_reset", obs, rst_vec);
        @(posedge clk);
        #1 chk("mid_reset_edge", obs, rst_vec);
        reset = 1'b0;
        #1 chk("mid_release_fetch", obs, step_vec(ST_FETCH, 6'b000000, 1'b0));

        run_random(20);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
